mitm_rule_engine: RTL and testbench
===================================

Name: mitm_rule_engine

Overview:
- MITM decision stage between the serial read buffers and the serial write buffers.
- On an eval request it latches the captured MISO/MOSI frame and scans a runtime-programmable rule table, one rule per cycle.
- Matching is on the MOSI frame. The first hit decides the fake MISO/MOSI data and mux selects; it then signals done to the control FSM.

Parameters:
- DATA_SIZE, 8, frame width in bits.
- NUM_RULES, 4, number of rule entries (2..16).
- RULE_IDX_W, 2, rule index width; must equal clog2(NUM_RULES).

Ports:
- sys_clk  in  1  system clock
- rst  in  1  reset
- eval  in  1  start request from control; level may stay high several cycles
- real_miso_data  in  DATA_SIZE  captured MISO frame
- real_mosi_data  in  DATA_SIZE  captured MOSI frame
- cfg_we  in  1  rule write strobe
- cfg_addr  in  RULE_IDX_W  rule index to write
- cfg_en  in  1  rule enable
- cfg_match  in  DATA_SIZE  MOSI compare value
- cfg_mask  in  DATA_SIZE  compare mask; 1 = bit compared
- cfg_fake_miso  in  DATA_SIZE  replacement MISO frame
- cfg_fake_mosi  in  DATA_SIZE  replacement MOSI frame
- cfg_sel  in  2  bit1 = select fake MISO, bit0 = select fake MOSI
- fake_miso_data  out  DATA_SIZE  to MISO write buffer
- fake_mosi_data  out  DATA_SIZE  to MOSI write buffer
- fake_miso_select  out  1  output mux select, MISO line
- fake_mosi_select  out  1  output mux select, MOSI line
- hit  out  1  last evaluation matched a rule
- hit_idx  out  RULE_IDX_W  index of the matching rule
- done_sig  out  1  one-cycle completion pulse

Behaviour:
- Clocking and reset: one clock, sys_clk. Reset rst is asynchronous, active-high.
- Reset values:
  - All outputs 0.
  - All rule entries 0, so every rule is disabled.
  - FSM in IDLE; internal eval_q = 0.
- Start condition: start = eval & ~eval_q, i.e. a rising edge of eval.
  - Honoured only in IDLE.
  - Ignored in SCAN and DONE; a held-high eval never retriggers.
- FSM:
  - IDLE: on start, latch real_miso_data and real_mosi_data into r_miso and r_mosi, set idx = 0, go to SCAN.
  - SCAN: evaluate rule[idx]. Hit if en=1 and ((r_mosi ^ match) & mask) == 0.
    - On hit, at the edge: fake_miso_data = rule.fake_miso, fake_mosi_data = rule.fake_mosi, selects = rule.sel, hit = 1, hit_idx = idx, done_sig = 1; go to DONE.
    - On miss with idx == NUM_RULES-1: fake_miso_data = r_miso, fake_mosi_data = r_mosi (passthrough), both selects 0, hit = 0, hit_idx = 0, done_sig = 1; go to DONE.
    - Otherwise idx++ and stay in SCAN.
  - DONE: done_sig returns to 0; go to IDLE.
- Latency:
  - done_sig rises k+1 cycles after the start edge, where k = hit index, or NUM_RULES-1 on a miss.
  - done_sig is exactly one cycle wide.
- Output hold: data, selects, hit and hit_idx hold until the next result edge.
- First hit wins. A mask of 0 matches any frame.
- Config writes:
  - Accepted in any state; the entry updates at the clock edge.
  - A rule evaluated in the same cycle as its write uses the old contents.
  - cfg_addr >= NUM_RULES: write dropped.
- Reset mid-scan: scan aborted, no done_sig, table cleared.

Optional Feature:
- Macro: MITM_ONESHOT_EN.
- Defined: a rule that hits has its en bit cleared at the same edge (auto-disarm). A cfg write to that same index in that cycle takes priority.
- Undefined: rules stay armed until rewritten.
- Port list is identical in both builds.

Decomposition:
- Shared package mitm_pkg:
  - FSM state encoding (IDLE, SCAN, DONE).
  - SEL_MISO_BIT = 1, SEL_MOSI_BIT = 0.
  - Rule-entry field layout/width constants.
- One natural sub-module: mitm_rule_table.
  - Rule register file with write port and index-addressed combinational read.
  - Owns the one-shot clear input.
- The scan FSM and match compare stay in mitm_rule_engine.

Test Plan (DATA_SIZE=8, NUM_RULES=4):
1. Reset, no writes; frame MISO=0x5A, MOSI=0x9F; eval -> done 4 cycles after start edge; fake data 0x5A/0x9F; selects 00; hit=0.
2. Rule2 = {en=1, match=0x9F, mask=0xFF, fake_miso=0xC3, sel=10}; MOSI=0x9F -> done 3 cycles after start; fake_miso_data=0xC3; fake_miso_select=1; hit_idx=2.
3. Rule0 mask=0xF0 match=0x90, rule1 exact 0x9F; MOSI=0x9F -> rule0 wins; done 1 cycle after start; hit_idx=0.
4. Hold eval high 5 cycles -> exactly one done_sig pulse; no rescan.
5. Assert rst during SCAN (rule3 pending) -> no done_sig; outputs 0; repeat eval -> miss, confirming table cleared.
6. With MITM_ONESHOT_EN: rule1 hits on 0x9F; second eval with same frame -> miss. Without the macro -> hit again, hit_idx=1.

Source files
------------

// File: rtl/mitm_pkg.sv
// Shared types and constants for the MITM rule engine.
package mitm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int SEL_MISO_BIT = 1;
   localparam int SEL_MOSI_BIT = 0;
   localparam int SEL_W        = 2;

   // A rule is en + match + mask + fake_miso + fake_mosi + sel.
   localparam int RULE_DATA_FIELDS = 4;

   function automatic int rule_bits(input int dsz);
      return 1 + RULE_DATA_FIELDS * dsz + SEL_W;
   endfunction

endpackage

// File: rtl/mitm_rule_table.sv
// Runtime-programmable rule register file.
// Write port has priority over the one-shot enable clear.
module mitm_rule_table
   import mitm_pkg::*;
#(
   parameter int DATA_SIZE  = 8,
   parameter int NUM_RULES  = 4,
   parameter int RULE_IDX_W = 2
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [RULE_IDX_W-1:0] waddr,
   input  logic                  wen,
   input  logic [DATA_SIZE-1:0]  wmatch,
   input  logic [DATA_SIZE-1:0]  wmask,
   input  logic [DATA_SIZE-1:0]  wfake_miso,
   input  logic [DATA_SIZE-1:0]  wfake_mosi,
   input  logic [SEL_W-1:0]      wsel,
   input  logic                  clr,
   input  logic [RULE_IDX_W-1:0] clr_idx,
   input  logic [RULE_IDX_W-1:0] rd_idx,
   output logic                  rd_en,
   output logic [DATA_SIZE-1:0]  rd_match,
   output logic [DATA_SIZE-1:0]  rd_mask,
   output logic [DATA_SIZE-1:0]  rd_fake_miso,
   output logic [DATA_SIZE-1:0]  rd_fake_mosi,
   output logic [SEL_W-1:0]      rd_sel
);

   logic [NUM_RULES-1:0] en_q;
   logic [DATA_SIZE-1:0] match_q [NUM_RULES];
   logic [DATA_SIZE-1:0] mask_q  [NUM_RULES];
   logic [DATA_SIZE-1:0] fmiso_q [NUM_RULES];
   logic [DATA_SIZE-1:0] fmosi_q [NUM_RULES];
   logic [SEL_W-1:0]     sel_q   [NUM_RULES];

   // Addresses with no matching slot are silently dropped.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         en_q <= '0;
         for (int i = 0; i < NUM_RULES; i++) begin
            match_q[i] <= '0;
            mask_q[i]  <= '0;
            fmiso_q[i] <= '0;
            fmosi_q[i] <= '0;
            sel_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_RULES; i++) begin
            if (we && waddr == RULE_IDX_W'(i)) begin
               en_q[i]    <= wen;
               match_q[i] <= wmatch;
               mask_q[i]  <= wmask;
               fmiso_q[i] <= wfake_miso;
               fmosi_q[i] <= wfake_mosi;
               sel_q[i]   <= wsel;
            end else if (clr && clr_idx == RULE_IDX_W'(i)) begin
               en_q[i] <= 1'b0;
            end
         end
      end
   end

   assign rd_en        = en_q[rd_idx];
   assign rd_match     = match_q[rd_idx];
   assign rd_mask      = mask_q[rd_idx];
   assign rd_fake_miso = fmiso_q[rd_idx];
   assign rd_fake_mosi = fmosi_q[rd_idx];
   assign rd_sel       = sel_q[rd_idx];

endmodule

// File: rtl/mitm_rule_engine.sv
// MITM decision stage: scans rules one per cycle, first MOSI hit wins.
// Define MITM_ONESHOT_EN to auto-disarm a rule when it hits.
module mitm_rule_engine
   import mitm_pkg::*;
#(
   parameter int DATA_SIZE  = 8,
   parameter int NUM_RULES  = 4,
   parameter int RULE_IDX_W = 2
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  eval,
   input  logic [DATA_SIZE-1:0]  real_miso_data,
   input  logic [DATA_SIZE-1:0]  real_mosi_data,
   input  logic                  cfg_we,
   input  logic [RULE_IDX_W-1:0] cfg_addr,
   input  logic                  cfg_en,
   input  logic [DATA_SIZE-1:0]  cfg_match,
   input  logic [DATA_SIZE-1:0]  cfg_mask,
   input  logic [DATA_SIZE-1:0]  cfg_fake_miso,
   input  logic [DATA_SIZE-1:0]  cfg_fake_mosi,
   input  logic [1:0]            cfg_sel,
   output logic [DATA_SIZE-1:0]  fake_miso_data,
   output logic [DATA_SIZE-1:0]  fake_mosi_data,
   output logic                  fake_miso_select,
   output logic                  fake_mosi_select,
   output logic                  hit,
   output logic [RULE_IDX_W-1:0] hit_idx,
   output logic                  done_sig
);

   localparam logic [RULE_IDX_W-1:0] LAST_IDX = RULE_IDX_W'(NUM_RULES - 1);

`ifdef MITM_ONESHOT_EN
   localparam bit ONESHOT = 1'b1;
`else
   localparam bit ONESHOT = 1'b0;
`endif

   state_t                state_q, state_d;
   logic                  eval_q;
   logic [RULE_IDX_W-1:0] idx_q, idx_d;
   logic [DATA_SIZE-1:0]  r_miso_q, r_miso_d;
   logic [DATA_SIZE-1:0]  r_mosi_q, r_mosi_d;
   logic [DATA_SIZE-1:0]  fmiso_d, fmosi_d;
   logic                  msel_d, osel_d, hit_d, done_d;
   logic [RULE_IDX_W-1:0] hit_idx_d;
   logic                  start, rule_hit, clr;

   logic                  rd_en;
   logic [DATA_SIZE-1:0]  rd_match, rd_mask;
   logic [DATA_SIZE-1:0]  rd_fake_miso, rd_fake_mosi;
   logic [SEL_W-1:0]      rd_sel;

   mitm_rule_table #(
      .DATA_SIZE  (DATA_SIZE),
      .NUM_RULES  (NUM_RULES),
      .RULE_IDX_W (RULE_IDX_W)
   ) u_table (
      .sys_clk      (sys_clk),
      .rst          (rst),
      .we           (cfg_we),
      .waddr        (cfg_addr),
      .wen          (cfg_en),
      .wmatch       (cfg_match),
      .wmask        (cfg_mask),
      .wfake_miso   (cfg_fake_miso),
      .wfake_mosi   (cfg_fake_mosi),
      .wsel         (cfg_sel),
      .clr          (clr),
      .clr_idx      (idx_q),
      .rd_idx       (idx_q),
      .rd_en        (rd_en),
      .rd_match     (rd_match),
      .rd_mask      (rd_mask),
      .rd_fake_miso (rd_fake_miso),
      .rd_fake_mosi (rd_fake_mosi),
      .rd_sel       (rd_sel)
   );

   assign start    = eval & ~eval_q;
   assign rule_hit = rd_en & (((r_mosi_q ^ rd_match) & rd_mask) == '0);

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         eval_q           <= 1'b0;
         idx_q            <= '0;
         r_miso_q         <= '0;
         r_mosi_q         <= '0;
         fake_miso_data   <= '0;
         fake_mosi_data   <= '0;
         fake_miso_select <= 1'b0;
         fake_mosi_select <= 1'b0;
         hit              <= 1'b0;
         hit_idx          <= '0;
         done_sig         <= 1'b0;
      end else begin
         state_q          <= state_d;
         eval_q           <= eval;
         idx_q            <= idx_d;
         r_miso_q         <= r_miso_d;
         r_mosi_q         <= r_mosi_d;
         fake_miso_data   <= fmiso_d;
         fake_mosi_data   <= fmosi_d;
         fake_miso_select <= msel_d;
         fake_mosi_select <= osel_d;
         hit              <= hit_d;
         hit_idx          <= hit_idx_d;
         done_sig         <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      r_miso_d  = r_miso_q;
      r_mosi_d  = r_mosi_q;
      fmiso_d   = fake_miso_data;
      fmosi_d   = fake_mosi_data;
      msel_d    = fake_miso_select;
      osel_d    = fake_mosi_select;
      hit_d     = hit;
      hit_idx_d = hit_idx;
      done_d    = 1'b0;
      clr       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               r_miso_d = real_miso_data;
               r_mosi_d = real_mosi_data;
               idx_d    = '0;
               state_d  = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (rule_hit) begin
               fmiso_d   = rd_fake_miso;
               fmosi_d   = rd_fake_mosi;
               msel_d    = rd_sel[SEL_MISO_BIT];
               osel_d    = rd_sel[SEL_MOSI_BIT];
               hit_d     = 1'b1;
               hit_idx_d = idx_q;
               done_d    = 1'b1;
               clr       = ONESHOT;
               state_d   = ST_DONE;
            end else if (idx_q == LAST_IDX) begin
               fmiso_d   = r_miso_q;
               fmosi_d   = r_mosi_q;
               msel_d    = 1'b0;
               osel_d    = 1'b0;
               hit_d     = 1'b0;
               hit_idx_d = '0;
               done_d    = 1'b1;
               state_d   = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mitm_rule_engine.sv
// Directed scoreboard bench for mitm_rule_engine (DATA_SIZE=8, NUM_RULES=4).
module tb_mitm_rule_engine;

   logic       sys_clk = 1'b0;
   logic       rst;
   logic       eval;
   logic [7:0] real_miso_data, real_mosi_data;
   logic       cfg_we, cfg_en;
   logic [1:0] cfg_addr, cfg_sel;
   logic [7:0] cfg_match, cfg_mask, cfg_fake_miso, cfg_fake_mosi;
   logic [7:0] fake_miso_data, fake_mosi_data;
   logic       fake_miso_select, fake_mosi_select, hit, done_sig;
   logic [1:0] hit_idx;

   typedef struct {
      logic [7:0] miso;
      logic [7:0] mosi;
      logic       msel;
      logic       osel;
      logic       hit;
      logic [1:0] idx;
      int         lat;
   } exp_t;

   exp_t q[$];
   exp_t last;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   t_start = 0;
   int   done_cnt = 0;
   logic prev_done = 1'b0;
   int   d0;

   mitm_rule_engine #(.DATA_SIZE(8), .NUM_RULES(4), .RULE_IDX_W(2)) dut (
      .sys_clk          (sys_clk),
      .rst              (rst),
      .eval             (eval),
      .real_miso_data   (real_miso_data),
      .real_mosi_data   (real_mosi_data),
      .cfg_we           (cfg_we),
      .cfg_addr         (cfg_addr),
      .cfg_en           (cfg_en),
      .cfg_match        (cfg_match),
      .cfg_mask         (cfg_mask),
      .cfg_fake_miso    (cfg_fake_miso),
      .cfg_fake_mosi    (cfg_fake_mosi),
      .cfg_sel          (cfg_sel),
      .fake_miso_data   (fake_miso_data),
      .fake_mosi_data   (fake_mosi_data),
      .fake_miso_select (fake_miso_select),
      .fake_mosi_select (fake_mosi_select),
      .hit              (hit),
      .hit_idx          (hit_idx),
      .done_sig         (done_sig)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] mi, input logic [7:0] mo,
                               input logic ms, input logic os, input logic h,
                               input logic [1:0] ix, input int lat);
      exp_t e;
      e.miso = mi; e.mosi = mo; e.msel = ms; e.osel = os;
      e.hit = h; e.idx = ix; e.lat = lat;
      return e;
   endfunction

   // Scoreboard consumer: one pop per done pulse.
   always @(negedge sys_clk) begin
      if (!rst && done_sig) begin
         exp_t e;
         done_cnt++;
         chk("done_width", {31'd0, prev_done}, 32'd0);
         if (q.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            last = e;
            chk("latency", cyc - t_start, e.lat);
            chk("fake_miso", {24'd0, fake_miso_data}, {24'd0, e.miso});
            chk("fake_mosi", {24'd0, fake_mosi_data}, {24'd0, e.mosi});
            chk("miso_sel", {31'd0, fake_miso_select}, {31'd0, e.msel});
            chk("mosi_sel", {31'd0, fake_mosi_select}, {31'd0, e.osel});
            chk("hit", {31'd0, hit}, {31'd0, e.hit});
            chk("hit_idx", {30'd0, hit_idx}, {30'd0, e.idx});
         end
      end
      prev_done = done_sig;
   end

   task automatic wr(input logic [1:0] a, input logic e, input logic [7:0] m,
                     input logic [7:0] k, input logic [7:0] fm,
                     input logic [7:0] fo, input logic [1:0] s);
      @(negedge sys_clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_en = e; cfg_match = m;
      cfg_mask = k; cfg_fake_miso = fm; cfg_fake_mosi = fo; cfg_sel = s;
      @(negedge sys_clk);
      cfg_we = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && q.size() != 0; i++) begin
         @(negedge sys_clk);
         #1;
      end
      chk(tag, q.size(), 32'd0);
      repeat (3) @(negedge sys_clk);
      chk({tag, "_hold_miso"}, {24'd0, fake_miso_data}, {24'd0, last.miso});
      chk({tag, "_hold_hit"}, {31'd0, hit}, {31'd0, last.hit});
   endtask

   task automatic run(input string tag, input logic [7:0] mi, input logic [7:0] mo,
                      input exp_t e, input int hold);
      @(negedge sys_clk);
      real_miso_data = mi;
      real_mosi_data = mo;
      eval = 1'b1;
      q.push_back(e);
      @(posedge sys_clk);
      #1 t_start = cyc;
      repeat (hold) @(negedge sys_clk);
      eval = 1'b0;
      drain(tag);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_miso"}, {24'd0, fake_miso_data}, 32'd0);
      chk({tag, "_mosi"}, {24'd0, fake_mosi_data}, 32'd0);
      chk({tag, "_sel"}, {30'd0, fake_miso_select, fake_mosi_select}, 32'd0);
      chk({tag, "_hit"}, {29'd0, hit, hit_idx}, 32'd0);
      chk({tag, "_done"}, {31'd0, done_sig}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; eval = 1'b0;
      real_miso_data = '0; real_mosi_data = '0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_en = 1'b0; cfg_sel = '0;
      cfg_match = '0; cfg_mask = '0; cfg_fake_miso = '0; cfg_fake_mosi = '0;
      repeat (3) @(negedge sys_clk);
      chk_zero("reset");
      rst = 1'b0;

      // 1: empty table -> passthrough miss
      run("t1", 8'h5A, 8'h9F, mk(8'h5A, 8'h9F, 0, 0, 0, 2'd0, 4), 1);

      // 2: rule2 exact match, fake MISO only
      wr(2'd2, 1, 8'h9F, 8'hFF, 8'hC3, 8'h00, 2'b10);
      run("t2", 8'h5A, 8'h9F, mk(8'hC3, 8'h00, 1, 0, 1, 2'd2, 3), 1);

      // 3: first hit wins (masked rule0 beats exact rule1)
      wr(2'd0, 1, 8'h90, 8'hF0, 8'h11, 8'h22, 2'b11);
      wr(2'd1, 1, 8'h9F, 8'hFF, 8'h33, 8'h44, 2'b01);
      run("t3", 8'h5A, 8'h9F, mk(8'h11, 8'h22, 1, 1, 1, 2'd0, 1), 1);

      // 4: eval held high -> single pulse
      d0 = done_cnt;
      wr(2'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
      wr(2'd1, 1, 8'h9F, 8'hFF, 8'h33, 8'h44, 2'b01);
      run("t4", 8'h00, 8'h9F, mk(8'h33, 8'h44, 0, 1, 1, 2'd1, 2), 5);
      chk("t4_pulses", done_cnt - d0, 32'd1);

      // 5: reset during scan with only rule3 armed
      wr(2'd1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
      wr(2'd2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
      wr(2'd3, 1, 8'h9F, 8'hFF, 8'hEE, 8'hDD, 2'b11);
      d0 = done_cnt;
      @(negedge sys_clk);
      real_miso_data = 8'hA5; real_mosi_data = 8'h9F; eval = 1'b1;
      @(negedge sys_clk);
      eval = 1'b0;
      @(negedge sys_clk);
      rst = 1'b1;
      #1 chk_zero("t5_rst");
      repeat (2) @(negedge sys_clk);
      rst = 1'b0;
      repeat (6) @(negedge sys_clk);
      chk("t5_no_done", done_cnt - d0, 32'd0);
      run("t5_cleared", 8'hA5, 8'h9F, mk(8'hA5, 8'h9F, 0, 0, 0, 2'd0, 4), 1);

      // 6: one-shot disarm vs persistent rule
      wr(2'd1, 1, 8'h9F, 8'hFF, 8'h66, 8'h77, 2'b11);
      run("t6a", 8'h12, 8'h9F, mk(8'h66, 8'h77, 1, 1, 1, 2'd1, 2), 1);
`ifdef MITM_ONESHOT_EN
      run("t6b", 8'h12, 8'h9F, mk(8'h12, 8'h9F, 0, 0, 0, 2'd0, 4), 1);
`else
      run("t6b", 8'h12, 8'h9F, mk(8'h66, 8'h77, 1, 1, 1, 2'd1, 2), 1);
`endif

      // 7: zero mask matches any frame
      wr(2'd3, 1, 8'hFF, 8'h00, 8'hAB, 8'hCD, 2'b01);
      run("t7", 8'h34, 8'h00, mk(8'hAB, 8'hCD, 0, 1, 1, 2'd3, 4), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
